// File: rtl/sm_warp_alloc.sv
// Warp-slot allocator: round-robin grant of free warp slots to TPC requests, registered dispatch,
// and a completion FIFO back to the TPC. Optional illegal-release checking via SM_WARP_ALLOC_CHK_EN.
module sm_warp_alloc #(
    parameter int NUM_WARP   = 8,
    parameter int DEPTH_WARP = $clog2(NUM_WARP),
    parameter int BID_W      = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tpc_req_valid_i,
    output logic                  tpc_req_ready_o,
    input  logic [BID_W-1:0]      tpc_req_bid_i,
    output logic                  sm_warp_req_valid_o,
    input  logic                  sm_warp_req_ready_i,
    output logic [DEPTH_WARP-1:0] sm_warp_req_wid_o,
    output logic [BID_W-1:0]      sm_warp_req_bid_o,
    input  logic                  sm_warp_rsp_valid_i,
    output logic                  sm_warp_rsp_ready_o,
    input  logic [DEPTH_WARP-1:0] sm_warp_rsp_wid_i,
    output logic                  tpc_rsp_valid_o,
    input  logic                  tpc_rsp_ready_i,
    output logic [DEPTH_WARP-1:0] tpc_rsp_wid_o,
    output logic [BID_W-1:0]      tpc_rsp_bid_o,
    output logic [DEPTH_WARP:0]   free_cnt_o,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int ENT_W = DEPTH_WARP + BID_W;
    localparam int CNT_W = DEPTH_WARP + 1;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_WARP-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_WARP; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    logic [NUM_WARP-1:0]   asg_q, asg_d;
    logic [DEPTH_WARP-1:0] rr_q, rr_d;
    logic [BID_W-1:0]      bid_table_q [NUM_WARP];
    logic                  disp_vld_q, disp_vld_d;
    logic [DEPTH_WARP-1:0] disp_wid_q, disp_wid_d;
    logic [BID_W-1:0]      disp_bid_q, disp_bid_d;
    logic [ENT_W-1:0]      fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        fcnt_q, fcnt_d;
    logic [CNT_W-1:0]      free_q, free_d;

    logic                  alloc_found, alloc, rsp_acc, rel_ok, push, pop;
    logic [DEPTH_WARP-1:0] alloc_wid, idx;
    logic [ENT_W-1:0]      head;

    // First free slot at or after the rr pointer; the index wraps naturally at NUM_WARP.
    always_comb begin
        alloc_found = 1'b0;
        alloc_wid   = '0;
        idx         = '0;
        for (int i = 0; i < NUM_WARP; i++) begin
            idx = rr_q + DEPTH_WARP'(i);
            if (!alloc_found && !asg_q[idx]) begin
                alloc_found = 1'b1;
                alloc_wid   = idx;
            end
        end
    end

    assign tpc_req_ready_o     = alloc_found & (~disp_vld_q | sm_warp_req_ready_i);
    assign alloc               = tpc_req_valid_i & tpc_req_ready_o;
    assign sm_warp_rsp_ready_o = (fcnt_q != (PTR_W+1)'(RSP_DEPTH));
    assign rsp_acc             = sm_warp_rsp_valid_i & sm_warp_rsp_ready_o;
    assign push                = rsp_acc & rel_ok;
    assign pop                 = (fcnt_q != '0) & tpc_rsp_ready_i;

`ifdef SM_WARP_ALLOC_CHK_EN
    logic err_q;
    assign rel_ok = asg_q[sm_warp_rsp_wid_i];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else if (rsp_acc && !rel_ok) err_q <= 1'b1;
    end
    assign err_o = err_q;
`else
    assign rel_ok = 1'b1;
    assign err_o  = 1'b0;
`endif

    always_comb begin
        asg_d = asg_q;
        if (push)  asg_d[sm_warp_rsp_wid_i] = 1'b0;
        if (alloc) asg_d[alloc_wid] = 1'b1;
        free_d = CNT_W'(NUM_WARP) - popcount(asg_d);
        rr_d   = alloc ? alloc_wid + 1'b1 : rr_q;

        disp_vld_d = disp_vld_q;
        disp_wid_d = disp_wid_q;
        disp_bid_d = disp_bid_q;
        if (alloc) begin
            disp_vld_d = 1'b1;
            disp_wid_d = alloc_wid;
            disp_bid_d = tpc_req_bid_i;
        end else if (sm_warp_req_ready_i) begin
            disp_vld_d = 1'b0;
        end

        unique case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + 1'b1;
            2'b01:   fcnt_d = fcnt_q - 1'b1;
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asg_q      <= '0;
            rr_q       <= '0;
            disp_vld_q <= 1'b0;
            disp_wid_q <= '0;
            disp_bid_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            free_q     <= CNT_W'(NUM_WARP);
        end else begin
            asg_q      <= asg_d;
            rr_q       <= rr_d;
            disp_vld_q <= disp_vld_d;
            disp_wid_q <= disp_wid_d;
            disp_bid_q <= disp_bid_d;
            fcnt_q     <= fcnt_d;
            free_q     <= free_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage arrays carry no reset; their contents are only observed behind valid state.
    always_ff @(posedge clk) begin
        if (alloc) bid_table_q[alloc_wid] <= tpc_req_bid_i;
        if (push)  fifo_q[wr_ptr_q] <= {sm_warp_rsp_wid_i, bid_table_q[sm_warp_rsp_wid_i]};
    end

    assign head                = fifo_q[rd_ptr_q];
    assign tpc_rsp_valid_o     = (fcnt_q != '0);
    assign tpc_rsp_wid_o       = tpc_rsp_valid_o ? head[ENT_W-1:BID_W] : '0;
    assign tpc_rsp_bid_o       = tpc_rsp_valid_o ? head[BID_W-1:0] : '0;
    assign sm_warp_req_valid_o = disp_vld_q;
    assign sm_warp_req_wid_o   = disp_wid_q;
    assign sm_warp_req_bid_o   = disp_bid_q;
    assign free_cnt_o          = free_q;
    assign idle_o              = (asg_q == '0) & ~disp_vld_q & (fcnt_q == '0);

endmodule

// File: tb/tb_sm_warp_alloc.sv
// Bench for sm_warp_alloc: directed scenarios plus randomized traffic against a queue-based model.
module tb_sm_warp_alloc;
    localparam int NW = 8;
    localparam int WW = $clog2(NW);
    localparam int BW = 4;
    localparam int RD = 4;

    logic clk, rst_n;
    logic req_v, req_rdy, sm_v, sm_rdy, rsp_v, rsp_rdy, tv, tpc_rdy, idle, err;
    logic [BW-1:0] req_bid, sm_bid, tbid;
    logic [WW-1:0] sm_wid, rsp_wid, twid;
    logic [WW:0]   free_cnt;

    int vec = 0;
    int errs = 0;

    sm_warp_alloc #(.NUM_WARP(NW), .BID_W(BW), .RSP_DEPTH(RD)) dut (
        .clk(clk), .rst_n(rst_n),
        .tpc_req_valid_i(req_v), .tpc_req_ready_o(req_rdy), .tpc_req_bid_i(req_bid),
        .sm_warp_req_valid_o(sm_v), .sm_warp_req_ready_i(sm_rdy),
        .sm_warp_req_wid_o(sm_wid), .sm_warp_req_bid_o(sm_bid),
        .sm_warp_rsp_valid_i(rsp_v), .sm_warp_rsp_ready_o(rsp_rdy), .sm_warp_rsp_wid_i(rsp_wid),
        .tpc_rsp_valid_o(tv), .tpc_rsp_ready_i(tpc_rdy),
        .tpc_rsp_wid_o(twid), .tpc_rsp_bid_o(tbid),
        .free_cnt_o(free_cnt), .idle_o(idle), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural reference: slot set, rr pointer, pending dispatch, completion queue.
    bit m_asg[NW];
    int m_bidt[NW];
    int m_rr;
    bit m_dv;
    int m_dwid, m_dbid;
    int m_fifo[$];
    bit m_err;

    function automatic int m_nfree();
        int n = 0;
        for (int i = 0; i < NW; i++) if (!m_asg[i]) n++;
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NW; i++) m_asg[i] = 0;
        m_rr = 0; m_dv = 0; m_dwid = 0; m_dbid = 0; m_err = 0;
        m_fifo.delete();
    endtask

    task automatic m_update();
        bit rdy, alloc, racc, legal, dopush;
        int aw, pv;
        rdy   = (m_nfree() > 0) && (!m_dv || sm_rdy);
        alloc = req_v && rdy;
        aw    = -1;
        if (alloc) begin
            for (int k = 0; k < NW; k++)
                if (aw < 0 && !m_asg[(m_rr + k) % NW]) aw = (m_rr + k) % NW;
        end
        racc  = rsp_v && (m_fifo.size() < RD);
        legal = 1;
`ifdef SM_WARP_ALLOC_CHK_EN
        legal = m_asg[rsp_wid];
        if (racc && !legal) m_err = 1;
`endif
        dopush = racc && legal;
        pv = (int'(rsp_wid) << BW) | m_bidt[rsp_wid];
        if (m_fifo.size() > 0 && tpc_rdy) void'(m_fifo.pop_front());
        if (dopush) begin
            m_fifo.push_back(pv);
            m_asg[rsp_wid] = 0;
        end
        if (alloc) begin
            m_asg[aw] = 1; m_bidt[aw] = int'(req_bid); m_rr = (aw + 1) % NW;
            m_dv = 1; m_dwid = aw; m_dbid = int'(req_bid);
        end else if (sm_rdy) begin
            m_dv = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic clr_in();
        req_v = 0; req_bid = '0; sm_rdy = 1; rsp_v = 0; rsp_wid = '0; tpc_rdy = 0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        m_reset();
    endtask

    task automatic fill_all();
        sm_rdy = 1;
        for (int k = 0; k < NW; k++) begin
            req_v = 1; req_bid = BW'(k);
            tick();
        end
        req_v = 0;
    endtask

    task automatic test_reset();
        logic [23:0] act, exp;
        do_reset();
        #1;
        act = {sm_v, sm_wid, sm_bid, tv, twid, tbid, free_cnt, idle, err};
        exp = {1'b0, WW'(0), BW'(0), 1'b0, WW'(0), BW'(0), (WW+1)'(NW), 1'b1, 1'b0};
        vec++;
        if (act !== exp) begin errs++; $display("FAIL reset_outputs: got %h expected %h", act, exp); end
        vec++;
        if (req_rdy !== 1'b1 || rsp_rdy !== 1'b1) begin
            errs++; $display("FAIL reset_ready: got req=%b rsp=%b expected 1/1", req_rdy, rsp_rdy);
        end
    endtask

    task automatic test_fill();
        do_reset();
        sm_rdy = 1;
        for (int k = 0; k < NW; k++) begin
            req_v = 1; req_bid = BW'(k);
            #1;
            vec++;
            if (req_rdy !== 1'b1 || free_cnt !== (WW+1)'(NW - k)) begin
                errs++; $display("FAIL fill_ready k=%0d: got rdy=%b free=%0d expected 1/%0d", k, req_rdy, free_cnt, NW - k);
            end
            if (k > 0) begin
                vec++;
                if (sm_v !== 1'b1 || sm_wid !== WW'(k - 1) || sm_bid !== BW'(k - 1)) begin
                    errs++; $display("FAIL fill_grant k=%0d: got v=%b wid=%0d bid=%0d expected 1/%0d/%0d", k, sm_v, sm_wid, sm_bid, k - 1, k - 1);
                end
            end
            tick();
        end
        req_v = 0;
        #1;
        vec++;
        if (sm_v !== 1'b1 || sm_wid !== WW'(NW - 1) || req_rdy !== 1'b0 || free_cnt !== '0) begin
            errs++; $display("FAIL fill_full: got v=%b wid=%0d rdy=%b free=%0d expected 1/7/0/0", sm_v, sm_wid, req_rdy, free_cnt);
        end
        tick();
        #1;
        vec++;
        if (sm_v !== 1'b0) begin errs++; $display("FAIL fill_drain: got v=%b expected 0", sm_v); end
    endtask

    task automatic test_release5();
        rsp_v = 1; rsp_wid = 3'd5;
        #1;
        vec++;
        if (rsp_rdy !== 1'b1 || tv !== 1'b0) begin
            errs++; $display("FAIL rel5_accept: got rdy=%b tv=%b expected 1/0", rsp_rdy, tv);
        end
        tick();
        rsp_v = 0;
        #1;
        vec++;
        if (tv !== 1'b1 || twid !== 3'd5 || tbid !== 4'd5 || free_cnt !== 4'd1 || req_rdy !== 1'b1) begin
            errs++; $display("FAIL rel5_rsp: got tv=%b wid=%0d bid=%0d free=%0d rdy=%b expected 1/5/5/1/1", tv, twid, tbid, free_cnt, req_rdy);
        end
        tpc_rdy = 1; req_v = 1; req_bid = 4'd9;
        tick();
        req_v = 0; tpc_rdy = 0;
        #1;
        vec++;
        if (sm_v !== 1'b1 || sm_wid !== 3'd5 || sm_bid !== 4'd9 || tv !== 1'b0 || free_cnt !== '0) begin
            errs++; $display("FAIL rel5_regrant: got v=%b wid=%0d bid=%0d tv=%b free=%0d expected 1/5/9/0/0", sm_v, sm_wid, sm_bid, tv, free_cnt);
        end
        rsp_v = 1; rsp_wid = 3'd2; tick();
        rsp_wid = 3'd7; tick();
        rsp_v = 0; tpc_rdy = 1; req_v = 1; req_bid = 4'd1;
        tick();
        req_v = 0;
        #1;
        vec++;
        if (sm_v !== 1'b1 || sm_wid !== 3'd7) begin
            errs++; $display("FAIL rr_after5: got v=%b wid=%0d expected 1/7", sm_v, sm_wid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        sm_rdy = 0; req_v = 1; req_bid = 4'd3;
        tick();
        req_bid = 4'd4;
        for (int c = 0; c < 3; c++) begin
            #1;
            vec++;
            if (sm_v !== 1'b1 || sm_wid !== 3'd0 || sm_bid !== 4'd3 || req_rdy !== 1'b0) begin
                errs++; $display("FAIL stall_hold c=%0d: got v=%b wid=%0d bid=%0d rdy=%b expected 1/0/3/0", c, sm_v, sm_wid, sm_bid, req_rdy);
            end
            tick();
        end
        sm_rdy = 1;
        #1;
        vec++;
        if (req_rdy !== 1'b1) begin errs++; $display("FAIL stall_release: got rdy=%b expected 1", req_rdy); end
        tick();
        req_v = 0;
        #1;
        vec++;
        if (sm_v !== 1'b1 || sm_wid !== 3'd1 || sm_bid !== 4'd4 || free_cnt !== 4'd6) begin
            errs++; $display("FAIL stall_next: got v=%b wid=%0d bid=%0d free=%0d expected 1/1/4/6", sm_v, sm_wid, sm_bid, free_cnt);
        end
        tick();
        #1;
        vec++;
        if (sm_v !== 1'b0) begin errs++; $display("FAIL stall_dup: got v=%b expected 0", sm_v); end
    endtask

    task automatic test_fifo_full();
        int expw;
        bit got5;
        do_reset();
        fill_all();
        tpc_rdy = 0;
        for (int k = 0; k < 5; k++) begin
            rsp_v = 1; rsp_wid = WW'(k);
            #1;
            vec++;
            if (rsp_rdy !== (k < RD)) begin
                errs++; $display("FAIL fifo_ready k=%0d: got %b expected %b", k, rsp_rdy, k < RD);
            end
            if (k < RD) tick();
        end
        expw = 0; got5 = 0;
        tpc_rdy = 1;
        for (int c = 0; c < 12 && expw < 5; c++) begin
            #1;
            if (rsp_v && rsp_rdy) got5 = 1;
            if (tv) begin
                vec++;
                if (twid !== WW'(expw) || tbid !== BW'(expw)) begin
                    errs++; $display("FAIL fifo_order: got wid=%0d bid=%0d expected %0d/%0d", twid, tbid, expw, expw);
                end
                expw++;
            end
            tick();
            if (got5) rsp_v = 0;
        end
        vec++;
        if (expw !== 5 || !got5) begin
            errs++; $display("FAIL fifo_drain: got %0d entries accepted5=%b expected 5/1", expw, got5);
        end
        tpc_rdy = 0;
    endtask

    task automatic test_same_cycle();
        do_reset();
        fill_all();
        rsp_v = 1; rsp_wid = 3'd2;
        tick();
        req_v = 1; req_bid = 4'hA; rsp_wid = 3'd6;
        #1;
        vec++;
        if (free_cnt !== 4'd1 || req_rdy !== 1'b1) begin
            errs++; $display("FAIL same_pre: got free=%0d rdy=%b expected 1/1", free_cnt, req_rdy);
        end
        tick();
        req_v = 0; rsp_v = 0;
        #1;
        vec++;
        if (free_cnt !== 4'd1 || sm_wid !== 3'd2 || sm_bid !== 4'hA) begin
            errs++; $display("FAIL same_cycle: got free=%0d wid=%0d bid=%0d expected 1/2/10", free_cnt, sm_wid, sm_bid);
        end
        req_v = 1; req_bid = 4'hB;
        tick();
        req_v = 0;
        #1;
        vec++;
        if (sm_v !== 1'b1 || sm_wid !== 3'd6) begin
            errs++; $display("FAIL same_next: got v=%b wid=%0d expected 1/6", sm_v, sm_wid);
        end
    endtask

    task automatic test_chk();
        do_reset();
`ifdef SM_WARP_ALLOC_CHK_EN
        rsp_v = 1; rsp_wid = 3'd3;
        tick();
        rsp_v = 0;
        #1;
        vec++;
        if (err !== 1'b1 || tv !== 1'b0 || free_cnt !== 4'd8) begin
            errs++; $display("FAIL chk_illegal: got err=%b tv=%b free=%0d expected 1/0/8", err, tv, free_cnt);
        end
        req_v = 1; tick(); req_v = 0; tick(); tick();
        #1;
        vec++;
        if (err !== 1'b1) begin errs++; $display("FAIL chk_sticky: got err=%b expected 1", err); end
`else
        rsp_v = 0;
        tick();
        #1;
        vec++;
        if (err !== 1'b0) begin errs++; $display("FAIL chk_off: got err=%b expected 0", err); end
`endif
    endtask

    task automatic test_random(input int ncyc, input bit mid_reset);
        int alist[$];
        logic [23:0] act, exp;
        bit erdy, etv;
        int hd;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            req_v   = ($urandom % 4) != 0;
            req_bid = BW'($urandom);
            sm_rdy  = ($urandom % 4) != 0;
            tpc_rdy = ($urandom % 3) != 0;
            alist.delete();
            for (int i = 0; i < NW; i++) if (m_asg[i]) alist.push_back(i);
            rsp_v = 0;
            if (alist.size() > 0 && ($urandom % 2) == 1) begin
                rsp_v = 1; rsp_wid = WW'(alist[$urandom % alist.size()]);
            end
`ifdef SM_WARP_ALLOC_CHK_EN
            if (($urandom % 10) == 0) begin rsp_v = 1; rsp_wid = WW'($urandom); end
`endif
            #1;
            if (mid_reset && c == ncyc / 2) begin
                rst_n = 0;
                #1;
                act = {sm_v, sm_wid, sm_bid, tv, twid, tbid, free_cnt, idle, err};
                exp = {1'b0, WW'(0), BW'(0), 1'b0, WW'(0), BW'(0), (WW+1)'(NW), 1'b1, 1'b0};
                vec++;
                if (act !== exp) begin errs++; $display("FAIL mid_reset: got %h expected %h", act, exp); end
                clr_in();
                @(negedge clk);
                rst_n = 1;
                m_reset();
                continue;
            end
            erdy = (m_nfree() > 0) && (!m_dv || sm_rdy);
            etv  = m_fifo.size() > 0;
            hd   = etv ? m_fifo[0] : 0;
            exp = {erdy, m_dv, WW'(m_dv ? m_dwid : 0), BW'(m_dv ? m_dbid : 0),
                   m_fifo.size() < RD, etv, WW'(hd >> BW), BW'(hd),
                   (WW+1)'(m_nfree()), (m_nfree() == NW) && !m_dv && !etv, m_err};
            act = {req_rdy, sm_v, m_dv ? sm_wid : WW'(0), m_dv ? sm_bid : BW'(0),
                   rsp_rdy, tv, etv ? twid : WW'(0), etv ? tbid : BW'(0),
                   free_cnt, idle, err};
            vec++;
            if (act !== exp) begin errs++; $display("FAIL random c=%0d: got %h expected %h", c, act, exp); end
            tick();
        end
        clr_in();
    endtask

    initial begin
        clr_in();
        rst_n = 0;
        m_reset();
        test_reset();
        test_fill();
        test_release5();
        test_stall();
        test_fifo_full();
        test_same_cycle();
        test_chk();
        test_random(400, 1'b0);
        test_random(300, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
